router_pkt_tx: RTL
==================

Name: router_pkt_tx

Overview:
Packet transmitter that drives the router's input port: pkt_valid, data_in and busy, with parity and error feedback. It accepts a packet command (destination, length, payload seed, parity-corrupt flag) and emits a header byte, LFSR-generated payload bytes and a parity byte, stalling whenever the router asserts busy. It then watches the router's error output for a fixed window and reports a per-packet result. It serves as the traffic source for router-level integration and self-test.

Parameters:
GAP_CYCLES, 3, cycles after the parity byte is accepted during which err is sampled before pkt_done.
CNT_W, 16, width of the sent-packet counter.

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at an edge
cmd_addr  input  2  destination port, 0..2 legal
cmd_len  input  6  payload length in bytes, 1..63 legal
cmd_seed  input  8  LFSR seed; 8'h00 is replaced by 8'h01
cmd_bad_parity  input  1  send inverted parity byte
cmd_err  output  1  1-cycle pulse: illegal command rejected
pkt_valid  output  1  to router; high for header and payload, low for parity
data_in  output  8  to router; byte under transfer
busy  input  1  from router; byte is not taken while high
err  input  1  from router parity error flag
pkt_done  output  1  1-cycle pulse at end of packet
pkt_err  output  1  valid with pkt_done: err was seen in the window
tx_count  output  CNT_W  packets completed, wraps at all-ones

Behaviour:
- Reset, synchronous: all outputs 0 at the next edge, state IDLE. This applies mid-packet: pkt_valid drops and data_in=0 at the same edge. cmd_ready rises the cycle after reset deasserts.
- Transfer rule: in HEADER, PAYLOAD or PARITY, a byte is accepted at an edge where busy==0. While busy==1, data_in and pkt_valid hold.
- States:
  - IDLE: cmd_ready=1, pkt_valid=0, data_in=0.
    - Accepted command with cmd_addr==3 or cmd_len==0: cmd_err pulses next cycle, stay IDLE, nothing driven.
    - Accepted legal command: latch the fields, load the LFSR with the seed, clear the parity accumulator and counter, then go to HEADER.
  - HEADER: pkt_valid=1, data_in={len[5:0],addr[1:0]}. On accept: parity=header, go to PAYLOAD.
  - PAYLOAD: pkt_valid=1, data_in=lfsr. On accept: parity^=lfsr, lfsr advances, cnt++. If cnt==len-1 at accept, go to PARITY.
  - PARITY: pkt_valid=0, data_in=bad_parity ? ~parity : parity. On accept: clear pkt_err_acc, load the gap counter with GAP_CYCLES, go to GAP.
  - GAP: pkt_valid=0, data_in=0. pkt_err_acc |= err each cycle; the gap counter decrements.
    - At 0: pkt_done=1 and pkt_err=pkt_err_acc for one cycle, tx_count++, go to IDLE.
- cmd_ready=0 outside IDLE; commands are not queued.
- LFSR: next={q[6:0], q[7]^q[5]^q[4]^q[3]}. The first payload byte equals the seed after zero substitution.
- Header byte is the first term of the parity; the parity byte itself is excluded.
- err is ignored outside GAP.
- busy high in IDLE or GAP has no effect.

Decomposition:
- Package router_pkt_pkg holds:
  - state enum: IDLE, HEADER, PAYLOAD, PARITY, GAP;
  - ADDR_W=2, LEN_W=6, DATA_W=8, ADDR_ILLEGAL=2'd3;
  - LFSR tap constant;
  - header-pack function.
- One sub-module, router_lfsr8: load, seed and advance inputs, q output, same clock and reset.

Test Plan:
- addr=1, len=3, seed=8'h01, busy=0: data_in 0D,01,02,04 with pkt_valid=1, then 0A with pkt_valid=0. pkt_done 3 cycles after the parity byte is accepted; pkt_err=0, tx_count=1.
- Same command with busy high for 2 cycles while 02 is on data_in: 02 holds for 3 cycles, no byte is skipped or duplicated, parity is still 0A.
- cmd_addr=3, or cmd_len=0: cmd_err pulses once, pkt_valid stays 0, cmd_ready stays 1, tx_count unchanged.
- addr=1, len=3, seed=8'h01, bad_parity=1: parity byte F5. Bench drives err=1 in GAP cycle 2, giving pkt_done with pkt_err=1.
- seed=8'h00, len=2, addr=2: header 0A, payload 01,02, parity 09.
- reset asserted while the second payload byte is on data_in: next edge gives pkt_valid=0, data_in=0, IDLE. A following legal command transmits correctly from its header.

Source files
------------

// File: rtl/router_pkt_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkt_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

    // Feedback taps q[7], q[5], q[4], q[3]; new bit enters at q[0].
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Fibonacci LFSR producing payload bytes; a zero seed is forced to 1
// so the register can never lock up.
module router_lfsr8
    import router_pkt_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] q
);

    // Load has priority over advance; both are qualified by the parent FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 8'h01;
        end else if (load) begin
            q <= (seed == '0) ? 8'h01 : seed;
        end else if (advance) begin
            q <= {q[DATA_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: header, LFSR payload and parity byte with busy
// back-pressure, followed by a fixed window that samples the router err flag.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a command
// HEADER  | header byte {len,addr} on data_in, pkt_valid=1
// PAYLOAD | LFSR bytes on data_in, pkt_valid=1
// PARITY  | parity byte on data_in, pkt_valid=0
// GAP     | watching err for GAP_CYCLES, then pkt_done
module router_pkt_tx
    import router_pkt_pkg::*;
#(
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic              cmd_bad_parity,
    output logic              cmd_err,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_in,
    input  logic              busy,
    input  logic              err,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [CNT_W-1:0]  tx_count
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t              state;
    state_t              state_nx;
    logic                armed;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic                bad_q;
    logic [DATA_W-1:0]   parity_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [GAP_W-1:0]    gap_q;
    logic                err_acc;
    logic [DATA_W-1:0]   lfsr_q;
    logic                cmd_fire;
    logic                cmd_illegal;
    logic                cmd_start;

    assign cmd_fire    = cmd_valid & cmd_ready;
    assign cmd_illegal = (cmd_addr == ADDR_ILLEGAL) || (cmd_len == '0);
    assign cmd_start   = cmd_fire & ~cmd_illegal;

    router_lfsr8 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (cmd_start),
        .seed    (cmd_seed),
        .advance ((state == PAYLOAD) && !busy),
        .q       (lfsr_q)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; byte states only move on when busy is low.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_start) state_nx = HEADER;
            HEADER:  if (!busy) state_nx = PAYLOAD;
            PAYLOAD: if (!busy && (cnt_q == len_q - LEN_W'(1))) state_nx = PARITY;
            PARITY:  if (!busy) state_nx = GAP;
            GAP:     if (gap_q == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Router-facing outputs decoded from the registered state.
    always_comb begin
        cmd_ready = (state == IDLE) && armed;
        pkt_valid = 1'b0;
        data_in   = '0;
        pkt_done  = 1'b0;
        pkt_err   = 1'b0;
        case (state)
            HEADER: begin
                pkt_valid = 1'b1;
                data_in   = pack_header(len_q, addr_q);
            end
            PAYLOAD: begin
                pkt_valid = 1'b1;
                data_in   = lfsr_q;
            end
            PARITY: data_in = bad_q ? ~parity_q : parity_q;
            GAP: begin
                pkt_done = (gap_q == '0);
                pkt_err  = (gap_q == '0) && err_acc;
            end
            default: ;
        endcase
    end

    // Command latch, parity/length/gap bookkeeping and packet counter.
    // armed keeps cmd_ready low for the first cycle after reset releases.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed    <= 1'b0;
            cmd_err  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            bad_q    <= 1'b0;
            parity_q <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            err_acc  <= 1'b0;
            tx_count <= '0;
        end else begin
            armed   <= 1'b1;
            cmd_err <= cmd_fire & cmd_illegal;
            case (state)
                IDLE: if (cmd_start) begin
                    addr_q   <= cmd_addr;
                    len_q    <= cmd_len;
                    bad_q    <= cmd_bad_parity;
                    parity_q <= '0;
                    cnt_q    <= '0;
                end
                HEADER: if (!busy) parity_q <= pack_header(len_q, addr_q);
                PAYLOAD: if (!busy) begin
                    parity_q <= parity_q ^ lfsr_q;
                    cnt_q    <= cnt_q + LEN_W'(1);
                end
                PARITY: if (!busy) begin
                    err_acc <= 1'b0;
                    gap_q   <= GAP_W'(GAP_CYCLES);
                end
                GAP: begin
                    if (gap_q == '0) begin
                        tx_count <= tx_count + CNT_W'(1);
                    end else begin
                        err_acc <= err_acc | err;
                        gap_q   <= gap_q - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
